cmac_usplus_tx_packet_queue: RTL
================================

# cmac_usplus_tx_packet_queue

- Parametrised packet-buffering successor to the single-packet CMAC TX emitter.
- Accepts a beat stream (valid/sop/eop/mty) and stores up to PKT_DEPTH complete packets in a data FIFO plus a descriptor FIFO.
- Issues one kick per committed packet to the CMAC TX engine, with byte count and busy/done handshake.
- Streams packet beats to the engine with backpressure; drops oversize or overflowing packets and retries unanswered kicks.

## Interface

Parameters:
- DATA_WIDTH, 512, beat width in bits; BYTES = DATA_WIDTH/8, power of two.
- MTY_WIDTH, 6, must equal log2(BYTES).
- DATA_DEPTH, 64, data FIFO depth in beats, power of two.
- PKT_DEPTH, 8, descriptor FIFO depth, power of two.
- BYTES_WIDTH, 14, width of packet byte count.
- KICK_TIMEOUT, 1024, cycles to wait for cmac_busy after kick.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- din_data  in  DATA_WIDTH  ingress beat.
- din_valid  in  1  beat present; no backpressure.
- din_sop  in  1  first beat of packet.
- din_eop  in  1  last beat of packet.
- din_mty  in  MTY_WIDTH  empty bytes in eop beat; ignored otherwise.
- dout_data  out  DATA_WIDTH  egress beat, valid when dout_valid.
- dout_valid  out  1  egress beat available.
- dout_ready  in  1  engine accepts beat.
- dout_last  out  1  final beat of current packet.
- dout_kick  out  1  transmit request.
- dout_bytes  out  BYTES_WIDTH  byte count of head packet, stable while kick/busy.
- cmac_busy  in  1  engine started TX.
- cmac_done  in  1  engine finished TX (one-cycle pulse).
- pkt_count  out  32  packets committed, wrapping.
- drop_count  out  16  packets dropped, saturating.
- timeout_count  out  16  kick timeouts, saturating.

## Operation

Ingress FSM (ING_IDLE, ING_PKT, ING_DROP):
- ING_IDLE: valid & sop writes beat, records packet start pointer, sets len (BYTES, or BYTES−mty if eop) → ING_PKT; sop & eop commits immediately and stays. Valid without sop is discarded silently.
- ING_PKT, valid without sop: write beat, len += BYTES (BYTES−mty on eop); eop commits → ING_IDLE.
- ING_PKT, valid & sop: abort current packet (rewind write pointer to start, drop_count+1), then treat the beat as a new sop.
- Drop causes: data FIFO full at a write; len would exceed 2^BYTES_WIDTH−1; descriptor FIFO full at eop. Action: rewind write pointer, drop_count+1, → ING_DROP (→ ING_IDLE if the dropping beat is eop).
- ING_DROP: discard beats until eop → ING_IDLE. A sop here starts a new packet as in ING_IDLE.
- Commit: push descriptor {len, beats = ceil(len/BYTES)}, advance committed write pointer, pkt_count+1.
- Data FIFO full/space uses the speculative write pointer; egress sees only committed beats.

Egress FSM (EG_IDLE, EG_KICK, EG_BUSY, EG_FLUSH):
- EG_IDLE: descriptor FIFO non-empty → dout_kick=1, dout_bytes=head len, timer cleared → EG_KICK.
- EG_KICK: cmac_busy → kick=0 → EG_BUSY. If timer reaches KICK_TIMEOUT → kick=0, timeout_count+1 → EG_IDLE; descriptor retained and re-kicked.
- EG_BUSY: dout_valid=1 while beats remain for the head packet; dout_valid & dout_ready pops one beat. dout_last=1 when remaining beats==1. cmac_done pops the descriptor → EG_IDLE if all beats were read, else → EG_FLUSH.
- EG_FLUSH: discard one remaining beat per cycle, dout_valid=0; → EG_IDLE after the last one.
- cmac_done outside EG_BUSY is ignored.

## Timing

- Reset: all outputs 0, both FSMs idle, FIFOs empty, counters 0. Reset mid-packet discards all stored and partial data.
- dout_* are registered. dout_data/dout_last are first-word-fall-through: valid in the same cycle as dout_valid.
- Eop at cycle t → descriptor visible t+1 → dout_kick high t+2 when egress is idle.
- Kick held until cmac_busy or timeout. After cmac_done, the next kick comes no earlier than 1 cycle after returning to EG_IDLE.
- Simultaneous commit and descriptor pop, or beat write and beat read, in the same cycle are both legal; occupancy updates by the net change.
- Byte arithmetic is BYTES_WIDTH+1 bits internally; overflow is detected before the store.

## Test plan

- Single beat, sop & eop, mty=4 → dout_bytes=60, kick at t+2; busy → kick low; one beat with dout_last; done → idle, pkt_count=1.
- 3-beat packet, last mty=0, then a 2-beat packet back-to-back → two kicks in order, bytes=192 then 128; beats in order with dout_ready toggling every other cycle.
- 65-beat packet with DATA_DEPTH=64, egress stalled → drop_count=1, no kick, the following 1-beat packet is kicked with bytes=64.
- 9 single-beat packets with PKT_DEPTH=8, busy never asserted → 8 commits, drop_count=1; KICK_TIMEOUT=16 gives timeout_count incrementing every 17 cycles with kick re-asserted.
- Sop mid-packet (sop, beat, sop+eop) → drop_count=1, one packet of BYTES−mty committed.
- 4-beat packet, cmac_done after 1 beat read → 3 beats flushed, next packet's first beat is the next dout_data; reset asserted during EG_BUSY → all outputs 0 next cycle.

Source files
------------

// File: rtl/cmac_usplus_tx_packet_queue.sv
// Purpose: buffers up to PKT_DEPTH whole packets and kicks the CMAC TX engine once per packet.
// Latency: eop at cycle t -> descriptor visible t+1 -> dout_kick at t+2 when egress idle.
// Backpressure: none on ingress (full/oversize packets are dropped); egress beats wait on dout_ready.
module cmac_usplus_tx_packet_queue #(
  parameter int DATA_WIDTH   = 512,
  parameter int MTY_WIDTH    = 6,
  parameter int DATA_DEPTH   = 64,
  parameter int PKT_DEPTH    = 8,
  parameter int BYTES_WIDTH  = 14,
  parameter int KICK_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  din_data,
  input  logic                   din_valid,
  input  logic                   din_sop,
  input  logic                   din_eop,
  input  logic [MTY_WIDTH-1:0]   din_mty,
  output logic [DATA_WIDTH-1:0]  dout_data,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   dout_last,
  output logic                   dout_kick,
  output logic [BYTES_WIDTH-1:0] dout_bytes,
  input  logic                   cmac_busy,
  input  logic                   cmac_done,
  output logic [31:0]            pkt_count,
  output logic [15:0]            drop_count,
  output logic [15:0]            timeout_count
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DAW   = $clog2(DATA_DEPTH);
  localparam int PAW   = $clog2(PKT_DEPTH);
  localparam int LW    = BYTES_WIDTH + 1;
  localparam int TW    = $clog2(KICK_TIMEOUT + 1);
  localparam logic [LW-1:0] LEN_MAX = {1'b0, {BYTES_WIDTH{1'b1}}};
  localparam logic [LW-1:0] BYTES_L = LW'(BYTES);

  typedef enum logic [1:0] {ING_IDLE, ING_PKT, ING_DROP} ing_state_e;
  typedef enum logic [1:0] {EG_IDLE, EG_KICK, EG_BUSY, EG_FLUSH} eg_state_e;

  logic [DATA_WIDTH-1:0]  data_mem  [DATA_DEPTH];
  logic [BYTES_WIDTH-1:0] len_mem   [PKT_DEPTH];
  logic [BYTES_WIDTH-1:0] beats_mem [PKT_DEPTH];

  ing_state_e ing_q, ing_d;
  eg_state_e  eg_q, eg_d;
  logic [DAW:0] wr_spec_q, wr_spec_d, wr_cmt_q, wr_cmt_d, rd_q, rd_d;
  logic [PAW:0] dwr_q, dwr_d, drd_q, drd_d;
  logic [LW-1:0] len_q, len_d;
  logic [31:0] pkt_q, pkt_d;
  logic [15:0] drop_q, drop_d, tmo_q, tmo_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BYTES_WIDTH-1:0] rem_q, rem_d, bytes_q, bytes_d;
  logic kick_q, kick_d, valid_q, valid_d, last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // A new packet always starts at the committed pointer, which doubles as the rewind target.
  logic [DAW:0]  wr_ptr;
  logic [LW-1:0] base_len, beat_bytes, new_len, len_round;
  logic          data_full, desc_full, desc_vld, len_over;
  logic          mem_we, desc_push;
  logic [1:0]    drop_inc;
  logic [16:0]   drop_sum;

  assign wr_ptr     = din_sop ? wr_cmt_q : wr_spec_q;
  assign base_len   = din_sop ? '0 : len_q;
  assign beat_bytes = din_eop ? (BYTES_L - LW'(din_mty)) : BYTES_L;
  assign new_len    = base_len + beat_bytes;
  assign len_round  = new_len + LW'(BYTES - 1);
  assign len_over   = new_len > LEN_MAX;
  assign data_full  = (wr_ptr - rd_q) == (DAW+1)'(DATA_DEPTH);
  assign desc_full  = (dwr_q - drd_q) == (PAW+1)'(PKT_DEPTH);
  assign desc_vld   = dwr_q != drd_q;

  // Ingress: accept, abort, drop or commit the incoming beat.
  always_comb begin
    ing_d     = ing_q;
    len_d     = len_q;
    wr_spec_d = wr_spec_q;
    wr_cmt_d  = wr_cmt_q;
    dwr_d     = dwr_q;
    pkt_d     = pkt_q;
    drop_inc  = 2'd0;
    mem_we    = 1'b0;
    desc_push = 1'b0;
    if (din_valid && (din_sop || ing_q == ING_PKT)) begin
      if (din_sop && ing_q == ING_PKT) drop_inc = 2'd1;
      if (data_full || len_over || (din_eop && desc_full)) begin
        wr_spec_d = wr_cmt_q;
        drop_inc  = drop_inc + 2'd1;
        ing_d     = din_eop ? ING_IDLE : ING_DROP;
      end else begin
        mem_we    = 1'b1;
        wr_spec_d = wr_ptr + (DAW+1)'(1);
        len_d     = new_len;
        if (din_eop) begin
          desc_push = 1'b1;
          wr_cmt_d  = wr_ptr + (DAW+1)'(1);
          dwr_d     = dwr_q + (PAW+1)'(1);
          pkt_d     = pkt_q + 32'd1;
          ing_d     = ING_IDLE;
        end else begin
          ing_d = ING_PKT;
        end
      end
    end else if (din_valid && ing_q == ING_DROP && din_eop) begin
      ing_d = ING_IDLE;
    end
    drop_sum = {1'b0, drop_q} + 17'(drop_inc);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Egress: kick / wait for busy / stream beats / flush leftovers after an early done.
  always_comb begin
    eg_d    = eg_q;
    timer_d = timer_q;
    rem_d   = rem_q;
    rd_d    = rd_q;
    drd_d   = drd_q;
    tmo_d   = tmo_q;
    kick_d  = kick_q;
    bytes_d = bytes_q;
    case (eg_q)
      EG_IDLE: if (desc_vld) begin
        kick_d  = 1'b1;
        bytes_d = len_mem[drd_q[PAW-1:0]];
        rem_d   = beats_mem[drd_q[PAW-1:0]];
        timer_d = '0;
        eg_d    = EG_KICK;
      end
      EG_KICK: if (cmac_busy) begin
        kick_d = 1'b0;
        eg_d   = EG_BUSY;
      end else if (timer_q == TW'(KICK_TIMEOUT - 1)) begin
        kick_d = 1'b0;
        eg_d   = EG_IDLE;
        tmo_d  = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
      EG_BUSY: begin
        if (valid_q && dout_ready) begin
          rd_d  = rd_q + (DAW+1)'(1);
          rem_d = rem_q - BYTES_WIDTH'(1);
        end
        if (cmac_done) begin
          drd_d = drd_q + (PAW+1)'(1);
          eg_d  = (rem_d == '0) ? EG_IDLE : EG_FLUSH;
        end
      end
      EG_FLUSH: begin
        rd_d  = rd_q + (DAW+1)'(1);
        rem_d = rem_q - BYTES_WIDTH'(1);
        if (rem_q == BYTES_WIDTH'(1)) eg_d = EG_IDLE;
      end
      default: eg_d = EG_IDLE;
    endcase
    valid_d = (eg_d == EG_BUSY) && (rem_d != '0);
    last_d  = valid_d && (rem_d == BYTES_WIDTH'(1));
    data_d  = valid_d ? data_mem[rd_d[DAW-1:0]] : '0;
  end

  // Storage arrays carry no reset; the pointers decide what is live.
  always_ff @(posedge clk) begin
    if (mem_we) data_mem[wr_ptr[DAW-1:0]] <= din_data;
    if (desc_push) begin
      len_mem[dwr_q[PAW-1:0]]   <= new_len[BYTES_WIDTH-1:0];
      beats_mem[dwr_q[PAW-1:0]] <= BYTES_WIDTH'(len_round >> MTY_WIDTH);
    end
  end

  // State, pointer, counter and registered-output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      ing_q <= ING_IDLE;    eg_q <= EG_IDLE;
      wr_spec_q <= '0;      wr_cmt_q <= '0;   rd_q <= '0;
      dwr_q <= '0;          drd_q <= '0;      len_q <= '0;
      pkt_q <= '0;          drop_q <= '0;     tmo_q <= '0;
      timer_q <= '0;        rem_q <= '0;      bytes_q <= '0;
      kick_q <= 1'b0;       valid_q <= 1'b0;  last_q <= 1'b0;
      data_q <= '0;
    end else begin
      ing_q <= ing_d;       eg_q <= eg_d;
      wr_spec_q <= wr_spec_d; wr_cmt_q <= wr_cmt_d; rd_q <= rd_d;
      dwr_q <= dwr_d;       drd_q <= drd_d;   len_q <= len_d;
      pkt_q <= pkt_d;       drop_q <= drop_d; tmo_q <= tmo_d;
      timer_q <= timer_d;   rem_q <= rem_d;   bytes_q <= bytes_d;
      kick_q <= kick_d;     valid_q <= valid_d; last_q <= last_d;
      data_q <= data_d;
    end
  end

  assign dout_data     = data_q;
  assign dout_valid    = valid_q;
  assign dout_last     = last_q;
  assign dout_kick     = kick_q;
  assign dout_bytes    = bytes_q;
  assign pkt_count     = pkt_q;
  assign drop_count    = drop_q;
  assign timeout_count = tmo_q;

endmodule
